// File: rtl/bus_arbiter_if.sv
// Signal bundle between bus_arbiter, the IF/MEM pipeline ports and the SRAM-style bus.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface bus_arbiter_if;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_ce;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_timeout;

  modport slave (
    input  if_ce, if_addr, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, flush,
           bus_rdata, bus_ack,
    output if_inst, mem_rdata, stallreq_if, stallreq_mem,
           bus_ce, bus_we, bus_sel, bus_addr, bus_wdata, bus_timeout
  );

  modport master (
    output if_ce, if_addr, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, flush,
           bus_rdata, bus_ack,
    input  if_inst, mem_rdata, stallreq_if, stallreq_mem,
           bus_ce, bus_we, bus_sel, bus_addr, bus_wdata, bus_timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one SRAM-style bus between instruction fetch and the MEM load/store port (MEM wins).
// Optional BUS_ARB_TIMEOUT_EN adds a BUSY watchdog that force-terminates a hung access.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  io
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_BUSY = 3'd1,
    IF_BUSY  = 3'd2,
    MEM_DONE = 3'd3,
    IF_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        killed_q, killed_d;
  logic        bus_ce_q, bus_ce_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic        busy;
  logic        kill_now;
  logic        expire;
  logic        fin;
  logic [31:0] rdata_eff;

  assign busy      = (state_q == MEM_BUSY) || (state_q == IF_BUSY);
  // a flush coinciding with the ack still kills the access
  assign kill_now  = killed_q | io.flush;
  assign fin       = io.bus_ack | expire;
  assign rdata_eff = io.bus_ack ? io.bus_rdata : 32'h0;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic       tmo_q;

  // terminate in the BUSY cycle whose increment reaches TIMEOUT-1
  assign expire = busy & ~io.bus_ack & ((cnt_q + 8'd1) == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= expire;
      if (state_q == IDLE) cnt_q <= 8'd0;
      else if (busy)       cnt_q <= cnt_q + 8'd1;
    end
  end

  assign io.bus_timeout = tmo_q;
`else
  assign expire         = 1'b0;
  assign io.bus_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    killed_d    = killed_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        killed_d = 1'b0;
        if (!io.flush) begin
          if (io.mem_ce) begin
            bus_ce_d    = 1'b1;
            bus_we_d    = io.mem_we;
            bus_sel_d   = io.mem_sel;
            bus_addr_d  = io.mem_addr;
            bus_wdata_d = io.mem_wdata;
            state_d     = MEM_BUSY;
          end else if (io.if_ce) begin
            bus_ce_d    = 1'b1;
            bus_we_d    = 1'b0;
            bus_sel_d   = 4'hF;
            bus_addr_d  = io.if_addr;
            state_d     = IF_BUSY;
          end
        end
      end

      MEM_BUSY, IF_BUSY: begin
        killed_d = kill_now;
        if (fin) begin
          bus_ce_d = 1'b0;
          if (kill_now) begin
            killed_d = 1'b0;
            state_d  = IDLE;
          end else if (state_q == MEM_BUSY) begin
            if (!bus_we_q) mem_rdata_d = rdata_eff;
            state_d = MEM_DONE;
          end else begin
            if_inst_d = rdata_eff;
            state_d   = IF_DONE;
          end
        end
      end

      MEM_DONE, IF_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      killed_q    <= 1'b0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      if_inst_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      killed_q    <= killed_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign io.bus_ce    = bus_ce_q;
  assign io.bus_we    = bus_we_q;
  assign io.bus_sel   = bus_sel_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wdata = bus_wdata_q;
  assign io.if_inst   = if_inst_q;
  assign io.mem_rdata = mem_rdata_q;

  // stall requests stay low while reset is held
  assign io.stallreq_mem = rst & io.mem_ce & (state_q != MEM_DONE);
  assign io.stallreq_if  = rst & io.if_ce  & (state_q != IF_DONE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: inputs change 1ns after a rising edge,
// outputs are checked on the falling edge of the same cycle.
module tb_bus_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bus_arbiter_if bif();

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bif.if_ce = 1'b1; bif.mem_ce = 1'b1; bif.if_addr = 32'h1234; bif.mem_addr = 32'h5678;
    tick; tick;
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL rst_bus_ce got=%h exp=0", bif.bus_ce); end total++;
    if (bif.bus_we !== 1'b0) begin bad++; $display("FAIL rst_bus_we got=%h exp=0", bif.bus_we); end total++;
    if (bif.bus_sel !== 4'h0) begin bad++; $display("FAIL rst_bus_sel got=%h exp=0", bif.bus_sel); end total++;
    if (bif.bus_addr !== 32'h0) begin bad++; $display("FAIL rst_bus_addr got=%h exp=0", bif.bus_addr); end total++;
    if (bif.bus_wdata !== 32'h0) begin bad++; $display("FAIL rst_bus_wdata got=%h exp=0", bif.bus_wdata); end total++;
    if (bif.if_inst !== 32'h0) begin bad++; $display("FAIL rst_if_inst got=%h exp=0", bif.if_inst); end total++;
    if (bif.mem_rdata !== 32'h0) begin bad++; $display("FAIL rst_mem_rdata got=%h exp=0", bif.mem_rdata); end total++;
    if (bif.stallreq_if !== 1'b0) begin bad++; $display("FAIL rst_stall_if got=%h exp=0", bif.stallreq_if); end total++;
    if (bif.stallreq_mem !== 1'b0) begin bad++; $display("FAIL rst_stall_mem got=%h exp=0", bif.stallreq_mem); end total++;
    if (bif.bus_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%h exp=0", bif.bus_timeout); end total++;
    bif.if_ce = 1'b0; bif.mem_ce = 1'b0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_fetch;
    bif.if_ce = 1'b1; bif.if_addr = 32'h80000000;
    @(negedge clk);
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL fetch_c0_stall got=%h exp=1", bif.stallreq_if); end total++;
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL fetch_c0_bus_ce got=%h exp=0", bif.bus_ce); end total++;
    tick;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h24010001;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL fetch_c1_bus_ce got=%h exp=1", bif.bus_ce); end total++;
    if (bif.bus_addr !== 32'h80000000) begin bad++; $display("FAIL fetch_c1_addr got=%h exp=80000000", bif.bus_addr); end total++;
    if (bif.bus_sel !== 4'hF) begin bad++; $display("FAIL fetch_c1_sel got=%h exp=f", bif.bus_sel); end total++;
    if (bif.bus_we !== 1'b0) begin bad++; $display("FAIL fetch_c1_we got=%h exp=0", bif.bus_we); end total++;
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.if_inst !== 32'h24010001) begin bad++; $display("FAIL fetch_c2_inst got=%h exp=24010001", bif.if_inst); end total++;
    if (bif.stallreq_if !== 1'b0) begin bad++; $display("FAIL fetch_c2_stall got=%h exp=0", bif.stallreq_if); end total++;
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL fetch_c2_bus_ce got=%h exp=0", bif.bus_ce); end total++;
    tick;
    bif.if_ce = 1'b0;
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL fetch_c3_bus_ce got=%h exp=0", bif.bus_ce); end total++;
    tick;
  endtask

  task automatic test_priority;
    bif.mem_ce = 1'b1; bif.mem_we = 1'b0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h80400000;
    bif.if_ce = 1'b1; bif.if_addr = 32'h80000004;
    @(negedge clk);
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL prio_c0_stall_if got=%h exp=1", bif.stallreq_if); end total++;
    if (bif.stallreq_mem !== 1'b1) begin bad++; $display("FAIL prio_c0_stall_mem got=%h exp=1", bif.stallreq_mem); end total++;
    tick;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h11112222;
    @(negedge clk);
    if (bif.bus_addr !== 32'h80400000) begin bad++; $display("FAIL prio_c1_addr got=%h exp=80400000", bif.bus_addr); end total++;
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL prio_c1_bus_ce got=%h exp=1", bif.bus_ce); end total++;
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL prio_c1_stall_if got=%h exp=1", bif.stallreq_if); end total++;
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.mem_rdata !== 32'h11112222) begin bad++; $display("FAIL prio_c2_rdata got=%h exp=11112222", bif.mem_rdata); end total++;
    if (bif.stallreq_mem !== 1'b0) begin bad++; $display("FAIL prio_c2_stall_mem got=%h exp=0", bif.stallreq_mem); end total++;
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL prio_c2_stall_if got=%h exp=1", bif.stallreq_if); end total++;
    tick;
    bif.mem_ce = 1'b0;
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL prio_c3_bus_ce got=%h exp=0", bif.bus_ce); end total++;
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL prio_c3_stall_if got=%h exp=1", bif.stallreq_if); end total++;
    tick;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hAAAA0004;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL prio_c4_bus_ce got=%h exp=1", bif.bus_ce); end total++;
    if (bif.bus_addr !== 32'h80000004) begin bad++; $display("FAIL prio_c4_addr got=%h exp=80000004", bif.bus_addr); end total++;
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL prio_c4_stall_if got=%h exp=1", bif.stallreq_if); end total++;
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.if_inst !== 32'hAAAA0004) begin bad++; $display("FAIL prio_c5_inst got=%h exp=aaaa0004", bif.if_inst); end total++;
    if (bif.stallreq_if !== 1'b0) begin bad++; $display("FAIL prio_c5_stall_if got=%h exp=0", bif.stallreq_if); end total++;
    tick;
    bif.if_ce = 1'b0;
    tick;
  endtask

  task automatic test_store;
    bif.mem_ce = 1'b1; bif.mem_we = 1'b1; bif.mem_sel = 4'b0011;
    bif.mem_addr = 32'h80400010; bif.mem_wdata = 32'hDEADBEEF;
    tick;
    // scramble the request side: the bus must keep the latched values
    bif.mem_we = 1'b0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h0; bif.mem_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin bif.bus_ack = 1'b1; bif.bus_rdata = 32'h55555555; end
      @(negedge clk);
      if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL store_busy%0d_ce got=%h exp=1", c, bif.bus_ce); end total++;
      if (bif.bus_we !== 1'b1) begin bad++; $display("FAIL store_busy%0d_we got=%h exp=1", c, bif.bus_we); end total++;
      if (bif.bus_sel !== 4'b0011) begin bad++; $display("FAIL store_busy%0d_sel got=%h exp=3", c, bif.bus_sel); end total++;
      if (bif.bus_addr !== 32'h80400010) begin bad++; $display("FAIL store_busy%0d_addr got=%h exp=80400010", c, bif.bus_addr); end total++;
      if (bif.bus_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_busy%0d_wdata got=%h exp=deadbeef", c, bif.bus_wdata); end total++;
      if (bif.stallreq_mem !== 1'b1) begin bad++; $display("FAIL store_busy%0d_stall got=%h exp=1", c, bif.stallreq_mem); end total++;
      tick;
    end
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.mem_rdata !== 32'h11112222) begin bad++; $display("FAIL store_done_rdata got=%h exp=11112222", bif.mem_rdata); end total++;
    if (bif.stallreq_mem !== 1'b0) begin bad++; $display("FAIL store_done_stall got=%h exp=0", bif.stallreq_mem); end total++;
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL store_done_ce got=%h exp=0", bif.bus_ce); end total++;
    tick;
    bif.mem_ce = 1'b0;
    tick;
  endtask

  task automatic test_flush;
    bif.if_ce = 1'b1; bif.if_addr = 32'h80000008;
    tick;
    tick;
    bif.flush = 1'b1;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL flush_busy2_ce got=%h exp=1", bif.bus_ce); end total++;
    tick;
    bif.flush = 1'b0;
    tick;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL flush_busy4_ce got=%h exp=1", bif.bus_ce); end total++;
    tick;
    bif.bus_ack = 1'b0; bif.if_addr = 32'h8000000C;
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL flush_idle_ce got=%h exp=0", bif.bus_ce); end total++;
    if (bif.if_inst !== 32'hAAAA0004) begin bad++; $display("FAIL flush_inst_kept got=%h exp=aaaa0004", bif.if_inst); end total++;
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL flush_no_done got=%h exp=1", bif.stallreq_if); end total++;
    tick;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h12345678;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL flush_regrant_ce got=%h exp=1", bif.bus_ce); end total++;
    if (bif.bus_addr !== 32'h8000000C) begin bad++; $display("FAIL flush_regrant_addr got=%h exp=8000000c", bif.bus_addr); end total++;
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.if_inst !== 32'h12345678) begin bad++; $display("FAIL flush_regrant_inst got=%h exp=12345678", bif.if_inst); end total++;
    if (bif.stallreq_if !== 1'b0) begin bad++; $display("FAIL flush_regrant_stall got=%h exp=0", bif.stallreq_if); end total++;
    tick;
    bif.if_ce = 1'b0;
    tick;
  endtask

  task automatic test_flush_ack_same;
    bif.mem_ce = 1'b1; bif.mem_we = 1'b0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h80400020;
    tick;
    bif.flush = 1'b1; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h77777777;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL fa_busy_ce got=%h exp=1", bif.bus_ce); end total++;
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL fa_idle_ce got=%h exp=0", bif.bus_ce); end total++;
    if (bif.mem_rdata !== 32'h11112222) begin bad++; $display("FAIL fa_rdata_kept got=%h exp=11112222", bif.mem_rdata); end total++;
    if (bif.stallreq_mem !== 1'b1) begin bad++; $display("FAIL fa_stall got=%h exp=1", bif.stallreq_mem); end total++;
    tick;
    bif.flush = 1'b0;
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL fa_flush_idle_no_grant got=%h exp=0", bif.bus_ce); end total++;
    tick;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h88888888;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL fa_regrant_ce got=%h exp=1", bif.bus_ce); end total++;
    if (bif.bus_addr !== 32'h80400020) begin bad++; $display("FAIL fa_regrant_addr got=%h exp=80400020", bif.bus_addr); end total++;
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.mem_rdata !== 32'h88888888) begin bad++; $display("FAIL fa_rdata got=%h exp=88888888", bif.mem_rdata); end total++;
    if (bif.stallreq_mem !== 1'b0) begin bad++; $display("FAIL fa_done_stall got=%h exp=0", bif.stallreq_mem); end total++;
    tick;
    bif.mem_ce = 1'b0;
    tick;
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bif.mem_ce = 1'b1; bif.mem_we = 1'b0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h80400030;
    bif.bus_rdata = 32'hFFFFFFFF;
    tick;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL tmo_busy%0d_ce got=%h exp=1", c, bif.bus_ce); end total++;
      if (bif.bus_timeout !== 1'b0) begin bad++; $display("FAIL tmo_busy%0d_pulse got=%h exp=0", c, bif.bus_timeout); end total++;
      tick;
    end
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL tmo_done_ce got=%h exp=0", bif.bus_ce); end total++;
    if (bif.mem_rdata !== 32'h0) begin bad++; $display("FAIL tmo_done_rdata got=%h exp=0", bif.mem_rdata); end total++;
    if (bif.bus_timeout !== 1'b1) begin bad++; $display("FAIL tmo_done_pulse got=%h exp=1", bif.bus_timeout); end total++;
    if (bif.stallreq_mem !== 1'b0) begin bad++; $display("FAIL tmo_done_stall got=%h exp=0", bif.stallreq_mem); end total++;
    tick;
    bif.mem_ce = 1'b0;
    @(negedge clk);
    if (bif.bus_timeout !== 1'b0) begin bad++; $display("FAIL tmo_idle_pulse got=%h exp=0", bif.bus_timeout); end total++;
    tick;
  endtask
`else
  task automatic test_no_timeout;
    bif.mem_ce = 1'b1; bif.mem_we = 1'b0; bif.mem_sel = 4'hF; bif.mem_addr = 32'h80400030;
    bif.bus_rdata = 32'hFFFFFFFF;
    tick;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL wait_busy%0d_ce got=%h exp=1", c, bif.bus_ce); end total++;
      if (bif.bus_timeout !== 1'b0) begin bad++; $display("FAIL wait_busy%0d_pulse got=%h exp=0", c, bif.bus_timeout); end total++;
      tick;
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.mem_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL wait_done_rdata got=%h exp=0badf00d", bif.mem_rdata); end total++;
    if (bif.bus_timeout !== 1'b0) begin bad++; $display("FAIL wait_done_pulse got=%h exp=0", bif.bus_timeout); end total++;
    tick;
    bif.mem_ce = 1'b0;
    tick;
  endtask
`endif

  task automatic test_reset_mid;
    bif.mem_ce = 1'b1; bif.mem_we = 1'b1; bif.mem_sel = 4'hC;
    bif.mem_addr = 32'h80400040; bif.mem_wdata = 32'h13572468;
    tick;
    #2;
    rst = 1'b0;
    #1;
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL rmid_ce got=%h exp=0", bif.bus_ce); end total++;
    if (bif.bus_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%h exp=0", bif.bus_we); end total++;
    if (bif.bus_sel !== 4'h0) begin bad++; $display("FAIL rmid_sel got=%h exp=0", bif.bus_sel); end total++;
    if (bif.bus_addr !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%h exp=0", bif.bus_addr); end total++;
    if (bif.bus_wdata !== 32'h0) begin bad++; $display("FAIL rmid_wdata got=%h exp=0", bif.bus_wdata); end total++;
    if (bif.mem_rdata !== 32'h0) begin bad++; $display("FAIL rmid_rdata got=%h exp=0", bif.mem_rdata); end total++;
    if (bif.if_inst !== 32'h0) begin bad++; $display("FAIL rmid_inst got=%h exp=0", bif.if_inst); end total++;
    if (bif.stallreq_mem !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%h exp=0", bif.stallreq_mem); end total++;
    bif.mem_ce = 1'b0; bif.mem_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick;
    bif.if_ce = 1'b1; bif.if_addr = 32'h80000010;
    @(negedge clk);
    if (bif.bus_ce !== 1'b0) begin bad++; $display("FAIL rmid_post_ce got=%h exp=0", bif.bus_ce); end total++;
    if (bif.stallreq_if !== 1'b1) begin bad++; $display("FAIL rmid_post_stall got=%h exp=1", bif.stallreq_if); end total++;
    tick;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h00000001;
    @(negedge clk);
    if (bif.bus_ce !== 1'b1) begin bad++; $display("FAIL rmid_grant_ce got=%h exp=1", bif.bus_ce); end total++;
    if (bif.bus_addr !== 32'h80000010) begin bad++; $display("FAIL rmid_grant_addr got=%h exp=80000010", bif.bus_addr); end total++;
    tick;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    if (bif.if_inst !== 32'h00000001) begin bad++; $display("FAIL rmid_inst_after got=%h exp=1", bif.if_inst); end total++;
    tick;
    bif.if_ce = 1'b0;
    tick;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bif.if_ce = 1'b0; bif.if_addr = 32'h0;
    bif.mem_ce = 1'b0; bif.mem_we = 1'b0; bif.mem_sel = 4'h0;
    bif.mem_addr = 32'h0; bif.mem_wdata = 32'h0;
    bif.flush = 1'b0; bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;

    test_reset;
    test_fetch;
    test_priority;
    test_store;
    test_flush;
    test_flush_ack_same;
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    test_reset_mid;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
